// File: rtl/out_byte_uart_tx.sv
// Serialises the CPU out_byte strobe stream onto an 8N1 UART line through a small FIFO.
// FIFO status, tx and tx_busy are all registered.
module out_byte_uart_tx #(
  parameter int DEPTH        = 16,
  parameter int CLKS_PER_BIT = 868
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [31:0]              out_byte,
  input  logic                     out_byte_en,
  output logic                     tx,
  output logic                     tx_busy,
  output logic                     fifo_empty,
  output logic                     fifo_full,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int BW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [AW:0]   COUNT_FULL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3} state_e;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic          empty_q, full_q, overflow_q, overflow_d;
  state_e        state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d, busy_q, busy_d;
  logic          push, pop;
  logic          unused_hi;

  assign unused_hi = ^out_byte[31:8];

  // A pop in the same cycle frees a slot, so a strobe while full is still accepted.
  assign push       = out_byte_en && (!full_q || pop);
  assign overflow_d = overflow_q || (out_byte_en && full_q && !pop);

  always_comb begin
    case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      empty_q    <= 1'b1;
      full_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q    <= count_d;
      empty_q    <= (count_d == '0);
      full_q     <= (count_d == COUNT_FULL);
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !reset) mem_q[wr_ptr_q] <= out_byte[7:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      baud_q    <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    pop       = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty_q) begin
          pop     = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          baud_d  = '0;
          state_d = START;
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        if (baud_q == BAUD_LAST) begin
          baud_d    = '0;
          bit_idx_d = 3'd0;
          state_d   = DATA;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      DATA: begin
        if (baud_q == BAUD_LAST) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      STOP: begin
        if (baud_q == BAUD_LAST) begin
          baud_d  = '0;
          state_d = IDLE;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Line level is derived from the next state so tx is registered yet aligned with the FSM.
  always_comb begin
    case (state_d)
      IDLE:    tx_d = 1'b1;
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      STOP:    tx_d = 1'b1;
      default: tx_d = 1'b1;
    endcase
    busy_d = (state_d != IDLE);
  end

  assign tx         = tx_q;
  assign tx_busy    = busy_q;
  assign fifo_empty = empty_q;
  assign fifo_full  = full_q;
  assign fifo_count = count_q;
  assign overflow   = overflow_q;
endmodule
